dcache_miss_controller: RTL and testbench
=========================================

# dcache_miss_controller

Sequencing FSM between the CPU load/store port and the direct-mapped, write-back, one-word-block data cache, with main memory behind it. It accepts one CPU request at a time and resolves it with a cache lookup. On a miss it writes back a dirty victim word, fetches the missing word, and fills the cache. It then completes the access and pulses `cpu_ready`. It also keeps saturating hit, miss and write-back counters for the performance monitor.

## Interface
- `STAT_W`, default 16: width of each statistics counter.
- `clk`  in  1  clock.
- `rst_b`  in  1  reset, asynchronous, active-low.
- `cpu_req`  in  1  request strobe; sampled only in IDLE.
- `cpu_we`  in  1  1 = store, 0 = load.
- `cpu_is_byte`  in  1  byte access (load sign-extends; store writes bits 7:0 only).
- `cpu_addr`  in  32  byte address.
- `cpu_wdata`  in  32  store data; bits 7:0 carry the byte for byte stores.
- `cpu_busy`  out  1  high in every state except IDLE.
- `cpu_ready`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  32  registered load result, valid while `cpu_ready` is high.
- `cache_addr`  out  32  address to the cache (always the latched request address).
- `cache_we`, `cache_is_byte`  out  1 each  cache write strobe and access size.
- `cache_wdata`  out  32  cache write data.
- `cache_rdata`  in  32  cache read data (combinational).
- `cache_hit`, `cache_dirty`  in  1 each  tag-match-and-valid flag, and dirty bit of the indexed line.
- `cache_miss_addr`  in  32  address of the resident (victim) word.
- `mem_req`, `mem_we`  out  1 each  memory request and write flag.
- `mem_addr`  out  32  word-aligned memory address.
- `mem_wdata`  out  32  write-back data.
- `mem_rdata`  in  32  fetch data, valid on `mem_ack`.
- `mem_ack`  in  1  one-cycle completion from memory.
- `hit_cnt`, `miss_cnt`, `wb_cnt`  out  STAT_W each  saturating statistics counters.

## Operation
- States: IDLE, COMPARE, WRITEBACK, FETCH, FILL, DONE.
- IDLE:
  - If `cpu_req` is high, latch `cpu_we`, `cpu_is_byte`, `cpu_addr` and `cpu_wdata`.
  - Clear the `refill` flag and go to COMPARE.
- COMPARE, with `cache_is_byte` = latched `is_byte`:
  - Hit, load: capture `cache_rdata` into `cpu_rdata` and go to DONE.
  - Hit, store: assert `cache_we` for this single cycle with `cache_wdata` = latched wdata, then go to DONE.
  - On a hit, `hit_cnt` increments only if `refill` = 0.
  - Miss: `miss_cnt` increments. Go to WRITEBACK if `cache_dirty` = 1, otherwise to FETCH.
- WRITEBACK:
  - Drive `mem_req` = 1, `mem_we` = 1, `mem_addr` = `cache_miss_addr` and `mem_wdata` = `cache_rdata`, with `cache_is_byte` = 0.
  - Hold these until `mem_ack`, then increment `wb_cnt` and go to FETCH.
- FETCH:
  - Drive `mem_req` = 1, `mem_we` = 0 and `mem_addr` = {addr[31:2], 2'b00}.
  - On `mem_ack`, latch `mem_rdata` and go to FILL.
- FILL:
  - Assert `cache_we` = 1 for one cycle with `cache_is_byte` = 0 and `cache_wdata` = the fetched word.
  - Set `refill` and go to COMPARE.
  - The fill always writes a full word. Its tag change leaves the line clean; the following store hit then marks it dirty.
- Write-allocate: a store miss always fetches and fills first, then writes in COMPARE. Word stores take this path too.
- DONE: `cpu_ready` = 1 for one cycle, then go to IDLE.
- Counters saturate at all-ones and never wrap.
- Outside the states named above, `cache_we` = 0, `mem_req` = 0 and `mem_we` = 0.

## Timing
- Reset (asynchronous, takes effect immediately):
  - State returns to IDLE, including mid-WRITEBACK or mid-FETCH, and `mem_req` drops at once.
  - `cpu_ready`, `cpu_busy`, `cache_we` and `mem_req` = 0; `cpu_rdata` = 0; all counters = 0.
- Hit: request accepted at cycle T (IDLE), COMPARE at T+1, `cpu_ready` at T+2.
- Clean miss with `mem_ack` at cycle A: FILL at A+1, COMPARE at A+2, `cpu_ready` at A+3.
- Dirty miss: the FETCH request starts the cycle after the write-back `mem_ack`.
- Memory handshake: `mem_ack` is ignored unless `mem_req` is high. Address and data stay stable from assertion of `mem_req` until `mem_ack`. `mem_ack` in the same cycle as `mem_req` is legal (one-cycle memory).
- `cpu_req` is ignored while `cpu_busy` is high. A request is accepted only in the IDLE cycle after DONE, never in the DONE cycle.

## Test plan
- Reset, then a word store to 0x0000_1004 with 0xDEADBEEF, then a word load from 0x0000_1004:
  - Store: one miss, a FETCH, then a write.
  - Load: `cpu_rdata` = 0xDEADBEEF at T+2; `hit_cnt` = 1, `miss_cnt` = 1, `wb_cnt` = 0.
- Conflict load from 0x0000_3004 after that store:
  - WRITEBACK with `mem_addr` = 0x0000_1004 and `mem_wdata` = 0xDEADBEEF, then a FETCH from 0x0000_3004.
  - `wb_cnt` = 1.
- Memory holds 0x0000_0080 at 0x2000; byte load from 0x2000 -> `cpu_rdata` = 0xFFFF_FF80.
- `mem_ack` delayed 7 cycles, with `cpu_req` pulsed while busy -> the extra request is ignored, `mem_addr` is stable throughout, and `cpu_ready` arrives at ack+3.
- `rst_b` asserted during FETCH -> `mem_req` = 0 immediately, state is IDLE, counters are 0; the next request completes normally.
- Preload `hit_cnt` near saturation and issue 0x10000 hits -> `hit_cnt` holds 0xFFFF and does not wrap.

Source files
------------

// File: rtl/dcache_miss_controller.sv
// dcache_miss_controller: sequences CPU loads/stores through a write-back, one-word-block cache and main memory
module dcache_miss_controller #(
   parameter int STAT_W = 16
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic              cpu_is_byte,
   input  logic [31:0]       cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic              cpu_busy,
   output logic              cpu_ready,
   output logic [31:0]       cpu_rdata,
   output logic [31:0]       cache_addr,
   output logic              cache_we,
   output logic              cache_is_byte,
   output logic [31:0]       cache_wdata,
   input  logic [31:0]       cache_rdata,
   input  logic              cache_hit,
   input  logic              cache_dirty,
   input  logic [31:0]       cache_miss_addr,
   output logic              mem_req,
   output logic              mem_we,
   output logic [31:0]       mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack,
   output logic [STAT_W-1:0] hit_cnt,
   output logic [STAT_W-1:0] miss_cnt,
   output logic [STAT_W-1:0] wb_cnt
);
   typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, FETCH, FILL, DONE} state_t;
   localparam logic [STAT_W-1:0] SAT = '1;
   state_t      state;
   logic        we_q;
   logic        byte_q;
   logic        refill;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] fill_q;
   // Cache strobes depend on the same-cycle hit, so they are decoded from state; victim data comes straight from the cache
   assign cache_addr    = addr_q;
   assign cache_we      = (state == COMPARE && cache_hit && we_q) || state == FILL;
   assign cache_is_byte = state == COMPARE && byte_q;
   assign cache_wdata   = state == FILL ? fill_q : wdata_q;
   assign mem_wdata     = cache_rdata;
   // Request sequencing, registered handshake outputs and saturating statistics
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state     <= IDLE;
         we_q      <= 1'b0;
         byte_q    <= 1'b0;
         refill    <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         fill_q    <= '0;
         cpu_busy  <= 1'b0;
         cpu_ready <= 1'b0;
         cpu_rdata <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         hit_cnt   <= '0;
         miss_cnt  <= '0;
         wb_cnt    <= '0;
      end else begin
         case (state)
            IDLE: if (cpu_req) begin
               we_q     <= cpu_we;
               byte_q   <= cpu_is_byte;
               addr_q   <= cpu_addr;
               wdata_q  <= cpu_wdata;
               refill   <= 1'b0;
               cpu_busy <= 1'b1;
               state    <= COMPARE;
            end
            COMPARE: if (cache_hit) begin
               if (!we_q) cpu_rdata <= cache_rdata;
               if (!refill) hit_cnt <= hit_cnt + STAT_W'(hit_cnt != SAT);
               cpu_ready <= 1'b1;
               state     <= DONE;
            end else begin
               miss_cnt <= miss_cnt + STAT_W'(miss_cnt != SAT);
               mem_req  <= 1'b1;
               mem_we   <= cache_dirty;
               mem_addr <= cache_dirty ? cache_miss_addr : {addr_q[31:2], 2'b00};
               state    <= cache_dirty ? WRITEBACK : FETCH;
            end
            WRITEBACK: if (mem_ack) begin
               wb_cnt   <= wb_cnt + STAT_W'(wb_cnt != SAT);
               mem_we   <= 1'b0;
               mem_addr <= {addr_q[31:2], 2'b00};
               state    <= FETCH;
            end
            FETCH: if (mem_ack) begin
               fill_q  <= mem_rdata;
               mem_req <= 1'b0;
               state   <= FILL;
            end
            FILL: begin
               refill <= 1'b1;
               state  <= COMPARE;
            end
            DONE: begin
               cpu_ready <= 1'b0;
               cpu_busy  <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dcache_miss_controller.sv
// tb_dcache_miss_controller: directed checks of the miss controller against a small cache and memory model
module tb_dcache_miss_controller;
   localparam int SW = 6;
   logic          clk, rst_b;
   logic          cpu_req, cpu_we, cpu_is_byte;
   logic [31:0]   cpu_addr, cpu_wdata;
   logic          cpu_busy, cpu_ready;
   logic [31:0]   cpu_rdata, cache_addr, cache_wdata, cache_rdata, cache_miss_addr;
   logic          cache_we, cache_is_byte, cache_hit, cache_dirty;
   logic          mem_req, mem_we, mem_ack;
   logic [31:0]   mem_addr, mem_wdata, mem_rdata;
   logic [SW-1:0] hit_cnt, miss_cnt, wb_cnt;
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int mem_delay = 0;
   int unstable = 0;
   int lg_n = 0;
   logic          lg_we [64];
   logic [31:0]   lg_addr [64];
   logic [31:0]   lg_data [64];
   int            lg_cyc [64];
   logic [31:0]   mem [16384];
   logic          cval [16] = '{default: 1'b0};
   logic          cdirty [16];
   logic [25:0]   ctag [16];
   logic [31:0]   cdata [16];
   logic [3:0]    idx;
   logic [7:0]    cb;

   dcache_miss_controller #(.STAT_W(SW)) dut (
      .clk(clk), .rst_b(rst_b),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_is_byte(cpu_is_byte),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_busy(cpu_busy), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
      .cache_addr(cache_addr), .cache_we(cache_we), .cache_is_byte(cache_is_byte),
      .cache_wdata(cache_wdata), .cache_rdata(cache_rdata), .cache_hit(cache_hit),
      .cache_dirty(cache_dirty), .cache_miss_addr(cache_miss_addr),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   // Cycle index used to measure latencies
   always @(posedge clk) cyc <= cyc + 1;

   // Direct-mapped cache lookup: 16 one-word lines, byte reads sign-extended
   always_comb begin
      idx             = cache_addr[5:2];
      cb              = cdata[idx][{cache_addr[1:0], 3'b000} +: 8];
      cache_hit       = cval[idx] && ctag[idx] == cache_addr[31:6];
      cache_dirty     = cval[idx] && cdirty[idx];
      cache_miss_addr = {ctag[idx], idx, 2'b00};
      cache_rdata     = cache_is_byte ? {{24{cb[7]}}, cb} : cdata[idx];
   end

   // Cache write: a hit dirties the line, a tag-changing fill installs it clean
   always @(posedge clk) begin
      if (cache_we) begin
         if (cache_hit) begin
            cdirty[idx] <= 1'b1;
            if (cache_is_byte) cdata[idx][{cache_addr[1:0], 3'b000} +: 8] <= cache_wdata[7:0];
            else cdata[idx] <= cache_wdata;
         end else begin
            cval[idx]   <= 1'b1;
            cdirty[idx] <= 1'b0;
            ctag[idx]   <= cache_addr[31:6];
            cdata[idx]  <= cache_wdata;
         end
      end
   end

   // Memory responder: acks after mem_delay extra cycles, logs each transfer, watches address stability
   initial begin
      int cnt;
      logic [31:0] hold;
      cnt = 0;
      hold = 0;
      mem_ack = 0;
      mem_rdata = 0;
      forever begin
         @(negedge clk);
         if (!mem_req) begin
            cnt = 0;
            mem_ack = 0;
         end else begin
            if (cnt == 0) hold = mem_addr;
            else if (mem_addr !== hold) unstable++;
            if (cnt == mem_delay) begin
               mem_ack = 1;
               mem_rdata = mem_we ? 32'h0 : mem[mem_addr[15:2]];
               lg_we[lg_n] = mem_we;
               lg_addr[lg_n] = mem_addr;
               lg_data[lg_n] = mem_wdata;
               lg_cyc[lg_n] = cyc;
               lg_n++;
               cnt = 0;
            end else begin
               mem_ack = 0;
               cnt++;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic we, input logic b, input logic [31:0] a, input logic [31:0] wd,
                        output int t0);
      @(negedge clk);
      cpu_req = 1;
      cpu_we = we;
      cpu_is_byte = b;
      cpu_addr = a;
      cpu_wdata = wd;
      t0 = cyc;
      @(negedge clk);
      cpu_req = 0;
   endtask

   task automatic wait_ready(output int rc);
      rc = -1;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (cpu_ready) begin
            rc = cyc;
            break;
         end
      end
   endtask

   task automatic access(input logic we, input logic b, input logic [31:0] a, input logic [31:0] wd,
                         output int lat);
      int t0, rc;
      issue(we, b, a, wd, t0);
      wait_ready(rc);
      lat = rc < 0 ? -1 : rc - t0;
   endtask

   initial begin
      int lat, base, t0, rc, seen;
      logic [SW-1:0] exp_hit;
      for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
      mem[32'h3004 >> 2] = 32'h1234_5678;
      mem[32'h2000 >> 2] = 32'h0000_0080;
      mem[32'h2008 >> 2] = 32'hCAFE_F00D;
      mem[32'h5000 >> 2] = 32'h55AA_55AA;
      rst_b = 0;
      cpu_req = 0;
      cpu_we = 0;
      cpu_is_byte = 0;
      cpu_addr = 0;
      cpu_wdata = 0;
      repeat (3) @(negedge clk);
      chk("rst_busy", cpu_busy, 0);
      chk("rst_ready", cpu_ready, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_cache_we", cache_we, 0);
      chk("rst_rdata", cpu_rdata, 0);
      chk("rst_hit", hit_cnt, 0);
      chk("rst_miss", miss_cnt, 0);
      chk("rst_wb", wb_cnt, 0);
      rst_b = 1;

      // Word store miss: clean line, fetch then write-allocate
      mem_delay = 2;
      base = lg_n;
      access(1, 0, 32'h0000_1004, 32'hDEAD_BEEF, lat);
      chk("st_miss_lat", lat, 7);
      chk("st_miss_xfers", lg_n - base, 1);
      chk("st_miss_fetch_we", lg_we[base], 0);
      chk("st_miss_fetch_addr", lg_addr[base], 32'h0000_1004);
      chk("st_miss_hit", hit_cnt, 0);
      chk("st_miss_miss", miss_cnt, 1);
      chk("st_miss_wb", wb_cnt, 0);

      // Load hit of the stored word
      access(0, 0, 32'h0000_1004, 0, lat);
      chk("ld_hit_lat", lat, 2);
      chk("ld_hit_data", cpu_rdata, 32'hDEAD_BEEF);
      chk("ld_hit_hit", hit_cnt, 1);
      chk("ld_hit_miss", miss_cnt, 1);
      chk("ld_hit_wb", wb_cnt, 0);

      // Conflict load evicts the dirty line
      mem_delay = 1;
      base = lg_n;
      access(0, 0, 32'h0000_3004, 0, lat);
      chk("wb_lat", lat, 8);
      chk("wb_xfers", lg_n - base, 2);
      chk("wb_we", lg_we[base], 1);
      chk("wb_addr", lg_addr[base], 32'h0000_1004);
      chk("wb_data", lg_data[base], 32'hDEAD_BEEF);
      chk("wb_fetch_we", lg_we[base+1], 0);
      chk("wb_fetch_addr", lg_addr[base+1], 32'h0000_3004);
      chk("wb_fetch_gap", lg_cyc[base+1] - lg_cyc[base], 2);
      chk("wb_data_out", cpu_rdata, 32'h1234_5678);
      chk("wb_cnt", wb_cnt, 1);
      chk("wb_miss", miss_cnt, 2);

      // Byte load miss with single-cycle memory, sign-extended result
      mem_delay = 0;
      access(0, 1, 32'h0000_2000, 0, lat);
      chk("byte_lat", lat, 5);
      chk("byte_data", cpu_rdata, 32'hFFFF_FF80);
      chk("byte_miss", miss_cnt, 3);

      // Slow memory with a stray request while busy
      mem_delay = 7;
      base = lg_n;
      issue(0, 0, 32'h0000_2008, 0, t0);
      repeat (3) @(negedge clk);
      cpu_req = 1;
      cpu_we = 1;
      cpu_addr = 32'h0000_4000;
      @(negedge clk);
      cpu_req = 0;
      wait_ready(rc);
      chk("slow_xfers", lg_n - base, 1);
      chk("slow_fetch_addr", lg_addr[base], 32'h0000_2008);
      chk("slow_ready_at_ack3", rc - lg_cyc[base], 3);
      chk("slow_data", cpu_rdata, 32'hCAFE_F00D);
      chk("slow_addr_stable", unstable, 0);
      repeat (2) @(negedge clk);
      chk("slow_idle", cpu_busy, 0);
      chk("slow_miss", miss_cnt, 4);
      chk("slow_no_extra", lg_n - base, 1);

      // Byte store hit then word load of the merged word
      access(1, 1, 32'h0000_3004, 32'h0000_00A5, lat);
      chk("bst_lat", lat, 2);
      access(0, 0, 32'h0000_3004, 0, lat);
      chk("bst_data", cpu_rdata, 32'h1234_56A5);
      chk("bst_hit", hit_cnt, 3);

      // Asynchronous reset in the middle of a fetch
      mem_delay = 50;
      issue(0, 0, 32'h0000_5000, 0, t0);
      seen = 0;
      for (int n = 0; n < 10 && !seen; n++) begin
         @(negedge clk);
         seen = mem_req;
      end
      chk("rstf_fetching", seen, 1);
      #2 rst_b = 0;
      #1;
      chk("rstf_mem_req", mem_req, 0);
      chk("rstf_busy", cpu_busy, 0);
      chk("rstf_rdata", cpu_rdata, 0);
      chk("rstf_hit", hit_cnt, 0);
      chk("rstf_miss", miss_cnt, 0);
      chk("rstf_wb", wb_cnt, 0);
      mem_delay = 1;
      @(negedge clk);
      rst_b = 1;
      access(0, 0, 32'h0000_5000, 0, lat);
      chk("rstf_after_lat", lat, 6);
      chk("rstf_after_data", cpu_rdata, 32'h55AA_55AA);
      chk("rstf_after_miss", miss_cnt, 1);

      // Hit counter saturation
      exp_hit = 0;
      for (int i = 0; i < 70; i++) begin
         access(0, 0, 32'h0000_5000, 0, lat);
         exp_hit = exp_hit == '1 ? exp_hit : exp_hit + 1'b1;
         chk("sat_hit", hit_cnt, exp_hit);
      end
      chk("sat_final", hit_cnt, 32'h3F);
      chk("final_addr_stable", unstable, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
